// File: rtl/timer_sched.sv
// timer_sched
// ---------------------------------------------------------------------------
// Round-robin scheduler that hands a single shared hardware counter to one
// of NREQ requesters at a time. The winner's delay is loaded into the counter's
// output-compare register. The counter is held in reset for one cycle (ARM)
// and then allowed to run (RUN). When the compare strobe arrives, the granted
// requester receives a one-cycle done pulse (DONE).
//
// A requester may abandon its request at any time while it is armed or
// running. An abandoned grant returns to IDLE without a done pulse.
//
// Parameters
//   N     : counter / delay width
//   NREQ  : number of requesters (2..8)
//
// Ports
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   req            : per-requester level request
//   req_delay      : per-requester delay, slice i = [i*N +: N]
//   gnt            : registered one-hot grant (all-zero in IDLE)
//   done           : one-cycle completion pulse to the granted requester
//   busy           : high whenever the FSM is not in IDLE
//   cnt_rst_n      : shared counter active-low reset
//   cnt_en         : shared counter enable
//   cnt_oc_en      : shared counter output-compare enable
//   cnt_oc_val     : shared counter output-compare value
//   cnt_oc_strobe  : compare-match strobe from the counter
// ---------------------------------------------------------------------------
module timer_sched #(
  parameter int N    = 16,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] req_delay,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              cnt_rst_n,
  output logic              cnt_en,
  output logic              cnt_oc_en,
  output logic [N-1:0]      cnt_oc_val,
  input  logic              cnt_oc_strobe
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_reg;
  logic [IW-1:0]   ptr_reg;     // round-robin start index
  logic [IW-1:0]   gidx_reg;    // index of the current grant holder

  logic [N-1:0]    delay_arr [NREQ];
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic [NREQ-1:0] win_onehot;
  logic            req_g;
  logic [IW-1:0]   g_next;

  // Split the flat delay bus into per-requester slices and build the
  // one-hot form of the arbitration winner.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign delay_arr[gi]  = req_delay[gi*N +: N];
      assign win_onehot[gi] = (win_idx == IW'(gi));
    end
  endgenerate

  // Round-robin search starting at ptr_reg. The loop walks from the farthest
  // candidate back toward ptr_reg so the closest requester is the last one
  // assigned and therefore wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_reg) + k) % NREQ);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // The holder's live request line is used for abort detection.
  assign req_g  = req[gidx_reg];

  // The next round-robin start is one past the holder, with wrap.
  // This applies on completion and on abort alike.
  assign g_next = (gidx_reg == IW'(NREQ - 1)) ? '0 : gidx_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      gidx_reg   <= '0;
      gnt        <= '0;
      done       <= '0;
      busy       <= 1'b0;
      cnt_rst_n  <= 1'b0;
      cnt_en     <= 1'b0;
      cnt_oc_en  <= 1'b0;
      cnt_oc_val <= '0;
    end else begin
      // done is a pulse; only the transitions into DONE raise it.
      done <= '0;
      case (state_reg)
        IDLE: begin
          cnt_rst_n <= 1'b0;
          cnt_en    <= 1'b0;
          cnt_oc_en <= 1'b0;
          if (win_found) begin
            state_reg  <= ARM;
            gnt        <= win_onehot;
            gidx_reg   <= win_idx;
            cnt_oc_val <= delay_arr[win_idx];
            busy       <= 1'b1;
          end
        end

        // One cycle with the counter held in reset, so each grant starts
        // counting from zero.
        ARM: begin
          if (!req_g) begin
            state_reg <= IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            ptr_reg   <= g_next;
            cnt_rst_n <= 1'b0;
            cnt_en    <= 1'b0;
            cnt_oc_en <= 1'b0;
          end else if (cnt_oc_val == '0) begin
            // A zero delay never starts the counter.
            state_reg <= DONE;
            done      <= gnt;
            cnt_rst_n <= 1'b0;
            cnt_en    <= 1'b0;
            cnt_oc_en <= 1'b0;
          end else begin
            state_reg <= RUN;
            cnt_rst_n <= 1'b1;
            cnt_en    <= 1'b1;
            cnt_oc_en <= 1'b1;
          end
        end

        // An abort takes priority over a simultaneous compare match.
        RUN: begin
          if (!req_g) begin
            state_reg <= IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            ptr_reg   <= g_next;
            cnt_rst_n <= 1'b0;
            cnt_en    <= 1'b0;
            cnt_oc_en <= 1'b0;
          end else if (cnt_oc_strobe) begin
            state_reg <= DONE;
            done      <= gnt;
            cnt_rst_n <= 1'b0;
            cnt_en    <= 1'b0;
            cnt_oc_en <= 1'b0;
          end
        end

        DONE: begin
          state_reg <= IDLE;
          gnt       <= '0;
          busy      <= 1'b0;
          ptr_reg   <= g_next;
          cnt_rst_n <= 1'b0;
          cnt_en    <= 1'b0;
          cnt_oc_en <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          gnt       <= '0;
          busy      <= 1'b0;
          cnt_rst_n <= 1'b0;
          cnt_en    <= 1'b0;
          cnt_oc_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched
// ---------------------------------------------------------------------------
// Directed test for timer_sched (N=16, NREQ=4). The bench plays the part of
// the shared counter by raising cnt_oc_strobe after the programmed number of
// RUN cycles. Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_timer_sched;

  localparam int N    = 16;
  localparam int NREQ = 4;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] req_delay;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic              cnt_rst_n;
  logic              cnt_en;
  logic              cnt_oc_en;
  logic [N-1:0]      cnt_oc_val;
  logic              cnt_oc_strobe;

  int total = 0;
  int bad   = 0;

  timer_sched #(.N(N), .NREQ(NREQ)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_delay     (req_delay),
    .gnt           (gnt),
    .done          (done),
    .busy          (busy),
    .cnt_rst_n     (cnt_rst_n),
    .cnt_en        (cnt_en),
    .cnt_oc_en     (cnt_oc_en),
    .cnt_oc_val    (cnt_oc_val),
    .cnt_oc_strobe (cnt_oc_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Checked fields, packed as {gnt, done, busy, cnt_en}.
  task automatic chk_core(input string tag, input logic [3:0] g, input logic [3:0] d,
                          input logic b, input logic en);
    chk(tag, {22'd0, gnt, done, busy, cnt_en}, {22'd0, g, d, b, en});
  endtask

  // Checked fields, packed as {cnt_rst_n, cnt_oc_en}.
  task automatic chk_cnt(input string tag, input logic rn, input logic oe);
    chk(tag, {30'd0, cnt_rst_n, cnt_oc_en}, {30'd0, rn, oe});
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  // Full grant: IDLE->ARM, run_len RUN cycles, then strobe, DONE, and IDLE.
  // Called on a falling edge whose following rising edge arbitrates.
  task automatic do_grant(input string tag, input logic [3:0] exp_g, input logic [15:0] exp_val,
                          input int run_len, input bit drop);
    step;
    chk_core({tag, "_arm"}, exp_g, 4'b0000, 1'b1, 1'b0);
    chk_cnt({tag, "_arm_cnt"}, 1'b0, 1'b0);
    chk({tag, "_val"}, 32'(cnt_oc_val), 32'(exp_val));
    for (int i = 0; i < run_len; i++) begin
      step;
      chk_core({tag, "_run"}, exp_g, 4'b0000, 1'b1, 1'b1);
      chk_cnt({tag, "_run_cnt"}, 1'b1, 1'b1);
      if (i == run_len - 1) cnt_oc_strobe = 1'b1;
    end
    step;
    cnt_oc_strobe = 1'b0;
    chk_core({tag, "_done"}, exp_g, exp_g, 1'b1, 1'b0);
    if (drop) req = '0;
    step;
    chk_core({tag, "_idle"}, 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk_cnt({tag, "_idle_cnt"}, 1'b0, 1'b0);
    chk({tag, "_hold"}, 32'(cnt_oc_val), 32'(exp_val));
    $display("txn %s gnt=%b delay=%0d run=%0d", tag, exp_g, exp_val, run_len);
  endtask

  initial begin
    rst_n         = 1'b0;
    req           = '0;
    req_delay     = '0;
    cnt_oc_strobe = 1'b0;

    // Reset state
    step;
    step;
    chk_core("rst", 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk_cnt("rst_cnt", 1'b0, 1'b0);
    chk("rst_val", 32'(cnt_oc_val), 32'd0);

    // Fairness: all four requesting, served 0,1,2,3,0; arbitration on first edge
    req_delay = {16'd3, 16'd3, 16'd3, 16'd3};
    req       = 4'b1111;
    rst_n     = 1'b1;
    do_grant("fair0", 4'b0001, 16'd3, 3, 1'b0);
    do_grant("fair1", 4'b0010, 16'd3, 3, 1'b0);
    do_grant("fair2", 4'b0100, 16'd3, 3, 1'b0);
    do_grant("fair3", 4'b1000, 16'd3, 3, 1'b0);
    do_grant("fair4", 4'b0001, 16'd3, 3, 1'b1);

    // Single request, delay 35 (ptr=1 wraps round to requester 0)
    req_delay        = '0;
    req_delay[15:0]  = 16'd35;
    req              = 4'b0001;
    do_grant("single", 4'b0001, 16'd35, 35, 1'b1);

    // Zero delay on requester 2: IDLE, ARM, DONE, IDLE, counter never enabled
    req = 4'b0100;
    step;
    chk_core("zd_arm", 4'b0100, 4'b0000, 1'b1, 1'b0);
    chk("zd_val", 32'(cnt_oc_val), 32'd0);
    step;
    chk_core("zd_done", 4'b0100, 4'b0100, 1'b1, 1'b0);
    req = '0;
    step;
    chk_core("zd_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    $display("txn zero_delay gnt=0100 delay=0");

    // Strobe while idle is ignored
    cnt_oc_strobe = 1'b1;
    step;
    chk_core("idle_strobe", 4'b0000, 4'b0000, 1'b0, 1'b0);
    cnt_oc_strobe = 1'b0;

    // Abort: requester 1, delay 100, dropped after 5 RUN cycles.
    // Requester 0 pulses meanwhile: it waits and is then ignored once it drops.
    req_delay[31:16] = 16'd100;
    req              = 4'b0010;
    step;
    chk_core("ab_arm", 4'b0010, 4'b0000, 1'b1, 1'b0);
    chk("ab_val", 32'(cnt_oc_val), 32'd100);
    for (int i = 0; i < 5; i++) begin
      step;
      chk_core("ab_run", 4'b0010, 4'b0000, 1'b1, 1'b1);
      if (i == 1) req[0] = 1'b1;
      if (i == 3) req[0] = 1'b0;
      if (i == 4) req[1] = 1'b0;
    end
    step;
    chk_core("ab_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk_cnt("ab_idle_cnt", 1'b0, 1'b0);
    step;
    chk_core("ab_stay", 4'b0000, 4'b0000, 1'b0, 1'b0);
    $display("txn abort gnt=0010 delay=100");

    // ptr=2 after the abort: requesters 1 and 2 asking -> 2 wins.
    // Collision: strobe and req[2] drop together -> abort, no done.
    req_delay[47:32] = 16'd7;
    req              = 4'b0110;
    step;
    chk_core("col_arm", 4'b0100, 4'b0000, 1'b1, 1'b0);
    step;
    chk_core("col_run", 4'b0100, 4'b0000, 1'b1, 1'b1);
    req           = 4'b0010;
    cnt_oc_strobe = 1'b1;
    step;
    cnt_oc_strobe = 1'b0;
    chk_core("col_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
    $display("txn collision gnt=0100 delay=7");

    // Requester 1 has waited and is now granted
    step;
    chk_core("rr_arm", 4'b0010, 4'b0000, 1'b1, 1'b0);
    chk("rr_val", 32'(cnt_oc_val), 32'd100);
    step;
    chk_core("rr_run", 4'b0010, 4'b0000, 1'b1, 1'b1);

    // Asynchronous reset between clock edges in RUN
    #2 rst_n = 1'b0;
    #1;
    chk_core("arst", 4'b0000, 4'b0000, 1'b0, 1'b0);
    chk_cnt("arst_cnt", 1'b0, 1'b0);
    chk("arst_val", 32'(cnt_oc_val), 32'd0);
    req = '0;
    step;
    chk_core("arst_hold", 4'b0000, 4'b0000, 1'b0, 1'b0);
    $display("txn async_reset during gnt=0010");

    // Release with requester 2 waiting: granted on the first edge (ptr=0)
    rst_n = 1'b1;
    req   = 4'b0100;
    step;
    chk_core("post_rst_arm", 4'b0100, 4'b0000, 1'b1, 1'b0);
    req = '0;
    step;
    chk_core("arm_abort", 4'b0000, 4'b0000, 1'b0, 1'b0);

    // ptr=3 now: requesters 0 and 3 -> 3 wins; abort in ARM wraps ptr to 0
    req = 4'b1001;
    step;
    chk_core("ptr3_arm", 4'b1000, 4'b0000, 1'b1, 1'b0);
    req = '0;
    step;
    chk_core("ptr3_abort", 4'b0000, 4'b0000, 1'b0, 1'b0);
    req = 4'b1001;
    step;
    chk_core("wrap_arm", 4'b0001, 4'b0000, 1'b1, 1'b0);
    req = '0;
    step;
    chk_core("wrap_abort", 4'b0000, 4'b0000, 1'b0, 1'b0);
    $display("txn ptr_wrap gnt=1000 then 0001");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_sched.md
TIMER_SCHED -- requirements
Module: timer_sched

Interface
REQ-001 Parameter N, default 16, SHALL set the counter width and the delay width.
REQ-002 Parameter NREQ, default 4, SHALL set the number of requesters (range 2..8).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous, active-low.
REQ-005 req  input  NREQ  SHALL carry per-requester level request; held until done or abandoned.
REQ-006 req_delay  input  NREQ*N  SHALL carry per-requester delay; slice i = bits [i*N +: N]; stable while req[i]=1.
REQ-007 gnt  output  NREQ  SHALL be a one-hot grant, registered.
REQ-008 done  output  NREQ  SHALL be a one-cycle completion pulse to the granted requester.
REQ-009 busy  output  1  SHALL be high whenever state is not IDLE.
REQ-010 cnt_rst_n  output  1  SHALL drive the shared counter's active-low reset.
REQ-011 cnt_en  output  1  SHALL drive the counter enable.
REQ-012 cnt_oc_en  output  1  SHALL drive the counter output-compare enable.
REQ-013 cnt_oc_val  output  N  SHALL drive the counter output-compare value.
REQ-014 cnt_oc_strobe  input  1  SHALL be the counter's compare-match strobe.

Function
REQ-015 FSM SHALL have states IDLE, ARM, RUN, DONE.
REQ-016 In IDLE with any req bit high, the block SHALL pick a winner by round-robin starting at index ptr, then ptr+1, with wrap modulo NREQ.
REQ-017 On that same edge, the block SHALL latch the winner into gnt, latch its req_delay into cnt_oc_val, and go to ARM.
REQ-018 ARM SHALL last exactly 1 cycle, with cnt_rst_n=0, cnt_en=0 and cnt_oc_en=0.
REQ-019 From ARM, a latched delay of 0 SHALL go to DONE; any other delay SHALL go to RUN.
REQ-020 In RUN, the block SHALL drive cnt_rst_n=1, cnt_en=1 and cnt_oc_en=1.
REQ-021 In RUN, cnt_oc_strobe sampled high SHALL move the FSM to DONE on the next edge.
REQ-022 DONE SHALL last 1 cycle: done[g]=1 for the granted index g, cnt_en=0, then go to IDLE.
REQ-023 On exit from DONE, ptr SHALL become (g+1) mod NREQ.
REQ-024 gnt SHALL stay constant and one-hot through ARM, RUN and DONE; it SHALL be all-zero in IDLE.
REQ-025 Abort: req[g] low in ARM or RUN SHALL send the FSM to IDLE next edge with no done pulse, cnt_en=0, and ptr=(g+1) mod NREQ.
REQ-026 req[g] low and cnt_oc_strobe high in the same RUN cycle SHALL be treated as an abort.
REQ-027 In IDLE, outputs SHALL be cnt_rst_n=0, cnt_en=0 and cnt_oc_en=0; cnt_oc_val SHALL hold its last value.
REQ-028 Requests arriving during a grant SHALL wait; no preemption is permitted.
REQ-029 A request dropped before it is granted SHALL be ignored.
REQ-030 cnt_oc_strobe outside RUN SHALL be ignored.
REQ-031 The N-bit delay SHALL be passed through unmodified, with no arithmetic on it.

Reset
REQ-032 rst_n low SHALL immediately force: state=IDLE, ptr=0, gnt=0, done=0, busy=0, cnt_rst_n=0, cnt_en=0, cnt_oc_en=0, cnt_oc_val=0.
REQ-033 Reset mid-RUN SHALL discard the active grant with no done pulse.
REQ-034 After rst_n rises, the first arbitration SHALL occur on the first clk edge.

Verification
REQ-035 Single request: req=0001, delay=35 -> gnt=0001 for ARM+RUN+DONE; done[0] exactly one cycle, one edge after strobe; busy low afterwards.
REQ-036 Fairness: req=1111 held with all delays=3 -> grants in order 0,1,2,3,0; each done pulse once per grant.
REQ-037 Zero delay: req=0100, delay=0 -> IDLE, ARM, DONE, IDLE; done[2] pulses; cnt_en never high.
REQ-038 Abort: req[1] dropped 5 cycles into RUN with delay=100 -> IDLE next edge, no done, cnt_en=0, ptr=2.
REQ-039 Async reset: rst_n pulsed low mid-RUN between clock edges -> all outputs reach reset values before the next edge; no done.
REQ-040 Collision: strobe and req[g] drop in the same cycle -> abort behaviour, no done pulse.
